// File: rtl/img_stream_gen_pkg.sv
// -----------------------------------------------------------------------------
// img_stream_pkg
// Shared types and helpers for the img_stream_gen frame source.
//   state_e            : frame sequencer states
//   DEF_*              : default image geometry and timing
//   width_for()        : bits needed to hold values 0..max_val (minimum 1)
//   max_of()           : larger of two ints, for sizing the shared segment timer
//   vsync_high_cycles(): number of cycles img_vsync stays high for one frame
// -----------------------------------------------------------------------------
package img_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    V_LEAD,
    ACTIVE,
    H_BLANK,
    V_TAIL
  } state_e;

  localparam int DEF_IMG_WIDTH   = 500;
  localparam int DEF_IMG_HEIGHT  = 500;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_V_LEAD_CYC  = 5;
  localparam int DEF_H_BLANK_CYC = 10;
  localparam int DEF_V_TAIL_CYC  = 1;

  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int vsync_high_cycles(input int w, input int h, input int lead,
                                           input int blank, input int tail);
    return lead + h * w + (h - 1) * blank + tail;
  endfunction

endpackage

// File: rtl/img_stream_gen_if.sv
// -----------------------------------------------------------------------------
// img_stream_gen_if
// Bundles the memory read port and the pixel stream of img_stream_gen.
//   rd_en / rd_addr / rd_data            : single-port read memory, 1-cycle latency
//   img_vsync / img_href / img_gray      : pixel stream towards the processing chain
//   busy / frame_done                    : frame status
// Modports:
//   master : the frame source (drives reads and the stream)
//   slave  : memory + stream consumer side
// -----------------------------------------------------------------------------
interface img_stream_gen_if
  import img_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 18
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              img_vsync;
  logic              img_href;
  logic [DATA_W-1:0] img_gray;
  logic              busy;
  logic              frame_done;

  modport master (
    output rd_en, rd_addr, img_vsync, img_href, img_gray, busy, frame_done,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, img_vsync, img_href, img_gray, busy, frame_done,
    output rd_data
  );

endinterface

// File: rtl/img_seg_cnt.sv
// -----------------------------------------------------------------------------
// img_seg_cnt
// Loadable down-counter with terminal-count flag. Used both as the per-segment
// cycle timer and as the remaining-lines counter of img_stream_gen.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : load i_load_val (has priority over i_dec)
//   i_load_val : value loaded; a segment of N cycles loads N-1
//   i_dec      : decrement by one; holds at zero instead of wrapping
//   o_tc       : counter is zero
// -----------------------------------------------------------------------------
module img_seg_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = (r_cnt == '0);

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values regardless of statement or process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !o_tc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/img_stream_gen.sv
// -----------------------------------------------------------------------------
// img_stream_gen
// Frame source: on a start pulse, reads IMG_WIDTH*IMG_HEIGHT pixels row-major
// from a 1-cycle-latency memory and emits them as a vsync/href/gray stream with
// a vsync lead, href-low blanking between lines and a vsync tail.
//   clk   : system clock
//   rst   : synchronous active-high reset (abandons a frame, no frame_done)
//   start : frame request, honoured only while busy is low
//   bus   : img_stream_gen_if master (memory read port, pixel stream, status)
// Stage 0 (state decode) drives the memory; the stream outputs are stage 0
// delayed one register so they line up with the returned read data.
// -----------------------------------------------------------------------------
module img_stream_gen
  import img_stream_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int V_LEAD_CYC  = DEF_V_LEAD_CYC,
  parameter int H_BLANK_CYC = DEF_H_BLANK_CYC,
  parameter int V_TAIL_CYC  = DEF_V_TAIL_CYC,
  parameter int ADDR_W      = width_for(IMG_WIDTH * IMG_HEIGHT - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  img_stream_gen_if.master bus
);

  localparam int N_PIX       = IMG_WIDTH * IMG_HEIGHT;
  localparam int SEG_MAX_LEN = max_of(max_of(V_LEAD_CYC, IMG_WIDTH),
                                      max_of(H_BLANK_CYC, V_TAIL_CYC));
  localparam int SEG_W       = width_for(SEG_MAX_LEN - 1);
  localparam int LINE_W      = width_for(IMG_HEIGHT - 1);

  // A segment of N cycles loads N-1 and ends on the cycle the timer hits zero.
  localparam logic [SEG_W-1:0]  LD_LEAD  = SEG_W'(V_LEAD_CYC - 1);
  localparam logic [SEG_W-1:0]  LD_ACT   = SEG_W'(IMG_WIDTH - 1);
  localparam logic [SEG_W-1:0]  LD_BLANK = SEG_W'(H_BLANK_CYC - 1);
  localparam logic [SEG_W-1:0]  LD_TAIL  = SEG_W'(V_TAIL_CYC - 1);
  localparam logic [LINE_W-1:0] LD_LINE  = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  state_e            r_state, w_state_nxt;
  logic              w_seg_load, w_seg_tc;
  logic [SEG_W-1:0]  w_seg_val;
  logic              w_line_load, w_line_dec, w_line_tc;
  logic              w_vs0, w_hs0, w_busy, w_accept, w_last_pix;
  logic [ADDR_W-1:0] r_addr;
  logic              r_vsync, r_href, r_frame_done;

  assign w_vs0      = (r_state != IDLE);
  assign w_hs0      = (r_state == ACTIVE);
  // Busy covers the extra output-stage cycle so a new frame cannot overlap the
  // vsync tail still leaving the register stage.
  assign w_busy     = w_vs0 | r_vsync;
  assign w_accept   = start & ~w_busy;
  assign w_last_pix = w_hs0 & w_seg_tc & w_line_tc;

  img_seg_cnt #(.CNT_W(SEG_W)) u_seg_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_seg_load),
    .i_load_val (w_seg_val),
    .i_dec      (w_vs0),
    .o_tc       (w_seg_tc)
  );

  img_seg_cnt #(.CNT_W(LINE_W)) u_line_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_line_load),
    .i_load_val (LD_LINE),
    .i_dec      (w_line_dec),
    .o_tc       (w_line_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_seg_load  = 1'b0;
    w_seg_val   = '0;
    w_line_load = 1'b0;
    w_line_dec  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = V_LEAD;
          w_seg_load  = 1'b1;
          w_seg_val   = LD_LEAD;
          w_line_load = 1'b1;
        end
      end
      V_LEAD, H_BLANK: begin
        if (w_seg_tc) begin
          w_state_nxt = ACTIVE;
          w_seg_load  = 1'b1;
          w_seg_val   = LD_ACT;
        end
      end
      ACTIVE: begin
        if (w_seg_tc) begin
          w_seg_load = 1'b1;
          if (w_line_tc) begin
            w_state_nxt = V_TAIL;
            w_seg_val   = LD_TAIL;
          end else begin
            w_state_nxt = H_BLANK;
            w_seg_val   = LD_BLANK;
            w_line_dec  = 1'b1;
          end
        end
      end
      V_TAIL: begin
        if (w_seg_tc) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address steps on every read except the final pixel, so it parks on the
  // last address instead of running past the image.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= '0;
    end else if (w_hs0 && !w_last_pix) begin
      r_addr <= r_addr + 1'b1;
    end
    if (!rst && w_last_pix) begin
      assert (r_addr == LAST_ADDR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_vsync      <= w_vs0;
      r_href       <= w_hs0;
      // Fires in the first cycle the delayed vsync is low after a frame.
      r_frame_done <= r_vsync & ~w_vs0;
    end
  end

  assign bus.rd_en      = w_hs0;
  assign bus.rd_addr    = r_addr;
  assign bus.img_vsync  = r_vsync;
  assign bus.img_href   = r_href;
  assign bus.img_gray   = r_href ? bus.rd_data : DATA_W'(0);
  assign bus.busy       = w_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_img_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_img_stream_gen
// Bench for img_stream_gen. DUT A is a 4x3 image (lead 2, blank 3, tail 1) with
// mem[i] = 0x10 + i; DUT B is the 1x1 image with all gaps of 1.
// Cycle numbering: the edge that samples start is edge 0; cycle n is the
// interval after edge n-1, observed on its falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_img_stream_gen;
  import img_stream_pkg::*;

  localparam int AW = 4, AH = 3, AL = 2, AB = 3, AT = 1;
  localparam int A_PIX  = AW * AH;
  localparam int A_AW   = width_for(A_PIX - 1);
  localparam int A_VLEN = vsync_high_cycles(AW, AH, AL, AB, AT);
  localparam int B_AW   = width_for(0);

  logic clk = 1'b0;
  logic rst, start_a, start_b;
  always #5 clk = ~clk;

  img_stream_gen_if #(.DATA_W(8), .ADDR_W(A_AW)) bus_a ();
  img_stream_gen_if #(.DATA_W(8), .ADDR_W(B_AW)) bus_b ();

  img_stream_gen #(
    .IMG_WIDTH(AW), .IMG_HEIGHT(AH), .DATA_W(8), .V_LEAD_CYC(AL),
    .H_BLANK_CYC(AB), .V_TAIL_CYC(AT), .ADDR_W(A_AW)
  ) dut_a (.clk(clk), .rst(rst), .start(start_a), .bus(bus_a));

  img_stream_gen #(
    .IMG_WIDTH(1), .IMG_HEIGHT(1), .DATA_W(8), .V_LEAD_CYC(1),
    .H_BLANK_CYC(1), .V_TAIL_CYC(1), .ADDR_W(B_AW)
  ) dut_b (.clk(clk), .rst(rst), .start(start_b), .bus(bus_b));

  // Memory models: registered read, data valid one cycle after rd_en.
  logic [7:0] mem_a [A_PIX];
  initial for (int i = 0; i < A_PIX; i++) mem_a[i] = 8'(8'h10 + i);

  always @(posedge clk) if (bus_a.rd_en) bus_a.rd_data <= mem_a[bus_a.rd_addr];
  always @(posedge clk) if (bus_b.rd_en) bus_b.rd_data <= 8'h5A;

  int abs_cyc = 0;
  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  int n_checks = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, abs_cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int         cyc;
    logic       vs, hs, busy, done, rden;
    logic [7:0] gray;
    int         addr;
  } exp_t;

  exp_t exp_q[$];

  // Pixel index emitted k cycles after the first pixel slot, or -1 in a gap.
  function automatic int pix_at(input int k);
    int l, col;
    if (k < 0) return -1;
    l   = k / (AW + AB);
    col = k % (AW + AB);
    if (l >= AH || col >= AW) return -1;
    return l * AW + col;
  endfunction

  // Expected cycles 1..last_rel of a frame whose start is sampled at the edge
  // after 'base'; cycles past 'cut' expect everything idle (reset hit).
  task automatic push_frame(input int base, input int cut, input int last_rel);
    exp_t e;
    int p, r;
    for (int c = 1; c <= last_rel; c++) begin
      e.cyc = base + c;
      if (c > cut) begin
        e.vs = 0; e.hs = 0; e.busy = 0; e.done = 0; e.rden = 0; e.gray = 8'h00; e.addr = -1;
      end else begin
        p      = pix_at(c - 2 - AL);
        r      = pix_at(c - 1 - AL);
        e.vs   = (c >= 2) && (c <= A_VLEN + 1);
        e.busy = (c <= A_VLEN + 1);
        e.done = (c == A_VLEN + 2);
        e.hs   = (p >= 0);
        e.gray = (p >= 0) ? mem_a[p] : 8'h00;
        e.rden = (r >= 0);
        e.addr = r;
      end
      exp_q.push_back(e);
    end
  endtask

  int   rise_q[$], fall_q[$], done_q[$];
  int   href_cnt = 0, last_addr = -1, first_addr = -1;
  logic prev_vs = 1'b0;
  exp_t mon_e;

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999;
  endfunction

  task automatic clear_logs();
    rise_q.delete(); fall_q.delete(); done_q.delete();
    href_cnt = 0; last_addr = -1; first_addr = -1;
  endtask

  // Monitor: event log, always-on invariants and scoreboard pop for DUT A.
  always @(negedge clk) begin
    if (abs_cyc >= 1) begin
      if (bus_a.img_vsync === 1'b1 && prev_vs === 1'b0) rise_q.push_back(abs_cyc);
      if (bus_a.img_vsync === 1'b0 && prev_vs === 1'b1) fall_q.push_back(abs_cyc);
      if (bus_a.frame_done === 1'b1) done_q.push_back(abs_cyc);
      if (bus_a.img_href === 1'b1) href_cnt++;
      if (bus_a.rd_en === 1'b1) begin
        last_addr = int'(bus_a.rd_addr);
        if (first_addr < 0) first_addr = int'(bus_a.rd_addr);
        check("rd_addr_bound", 32'(bus_a.rd_addr > A_AW'(A_PIX - 1)), 32'd0);
      end
      if (bus_a.img_href !== 1'b1) check("gray_mask", 32'(bus_a.img_gray), 32'd0);
      prev_vs = bus_a.img_vsync;
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == abs_cyc) begin
      mon_e = exp_q.pop_front();
      check("vsync",      32'(bus_a.img_vsync),  32'(mon_e.vs));
      check("href",       32'(bus_a.img_href),   32'(mon_e.hs));
      check("gray",       32'(bus_a.img_gray),   32'(mon_e.gray));
      check("busy",       32'(bus_a.busy),       32'(mon_e.busy));
      check("frame_done", 32'(bus_a.frame_done), 32'(mon_e.done));
      check("rd_en",      32'(bus_a.rd_en),      32'(mon_e.rden));
      if (mon_e.addr >= 0) check("rd_addr", 32'(bus_a.rd_addr), 32'(mon_e.addr));
    end
  end

  // Wait (from a falling edge) until the falling edge of absolute cycle t.
  task automatic goto(input int t);
    int n = 0;
    while (abs_cyc != t) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        $display("FAIL goto: cycle %0d not reached, at %0d", t, abs_cyc);
        $fatal(1, "bench timeout");
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", abs_cyc);
    $fatal(1, "watchdog");
  end

  // DUT B trace, cycles 1..6: {vsync, href, busy, frame_done, rd_en, gray}
  logic [12:0] b_tab [6];

  initial begin
    int b;
    b_tab = '{13'b0_0_1_0_0_00000000,
              13'b1_0_1_0_1_00000000,
              13'b1_1_1_0_0_01011010,
              13'b1_0_1_0_0_00000000,
              13'b0_0_0_1_0_00000000,
              13'b0_0_0_0_0_00000000};
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);

    // Reset state
    check("rst_vsync", 32'(bus_a.img_vsync),  32'd0);
    check("rst_href",  32'(bus_a.img_href),   32'd0);
    check("rst_gray",  32'(bus_a.img_gray),   32'd0);
    check("rst_busy",  32'(bus_a.busy),       32'd0);
    check("rst_done",  32'(bus_a.frame_done), 32'd0);
    check("rst_rd_en", 32'(bus_a.rd_en),      32'd0);
    check("rst_b_busy", 32'(bus_b.busy),      32'd0);
    rst = 1'b0;

    // Basic timing, stray starts at 5 and 22 ignored, accepted start at 23
    clear_logs();
    b = abs_cyc + 2;
    push_frame(b, 1000, A_VLEN + 2);
    push_frame(b + 23, 1000, A_VLEN + 2);
    goto(b);      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    goto(b + 5);  start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    goto(b + 22); start_a = 1'b1; goto(b + 24);  start_a = 1'b0;
    goto(b + 47);
    check("vsync_rise_1",  32'(qget(rise_q, 0) - b), 32'd2);
    check("vsync_fall_1",  32'(qget(fall_q, 0) - b), 32'd23);
    check("vsync_len_1",   32'(qget(fall_q, 0) - qget(rise_q, 0)), 32'd21);
    check("done_1",        32'(qget(done_q, 0) - b), 32'd23);
    check("vsync_rise_2",  32'(qget(rise_q, 1) - b), 32'd25);
    check("done_2",        32'(qget(done_q, 1) - b), 32'd46);
    check("frame_count",   32'(done_q.size()), 32'd2);
    check("href_count",    32'(href_cnt), 32'd24);
    check("last_rd_addr",  32'(last_addr), 32'd11);

    // Mid-frame reset at cycle 12
    clear_logs();
    b = abs_cyc + 2;
    push_frame(b, 12, 30);
    goto(b);      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    goto(b + 12); rst = 1'b1; @(negedge clk); rst = 1'b0;
    goto(b + 31);
    check("rst_mid_no_done", 32'(done_q.size()), 32'd0);
    check("rst_mid_href",    32'(href_cnt), 32'd6);

    // Full frame after the abandoned one restarts at address 0
    clear_logs();
    b = abs_cyc + 2;
    push_frame(b, 1000, A_VLEN + 2);
    goto(b); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    goto(b + 25);
    check("restart_first_addr", 32'(first_addr), 32'd0);
    check("restart_last_addr",  32'(last_addr), 32'd11);
    check("restart_rise",       32'(qget(rise_q, 0) - b), 32'd2);
    check("restart_done",       32'(qget(done_q, 0) - b), 32'd23);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Degenerate 1x1 frame
    b = abs_cyc + 1;
    goto(b); start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      goto(b + r);
      check("b_vsync", 32'(bus_b.img_vsync),  32'(b_tab[r-1][12]));
      check("b_href",  32'(bus_b.img_href),   32'(b_tab[r-1][11]));
      check("b_busy",  32'(bus_b.busy),       32'(b_tab[r-1][10]));
      check("b_done",  32'(bus_b.frame_done), 32'(b_tab[r-1][9]));
      check("b_rd_en", 32'(bus_b.rd_en),      32'(b_tab[r-1][8]));
      check("b_gray",  32'(bus_b.img_gray),   32'(b_tab[r-1][7:0]));
      if (r == 2) check("b_rd_addr", 32'(bus_b.rd_addr), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/img_stream_gen.md
Name: img_stream_gen

Overview:
Synthesizable frame source that reads a grayscale image from a single-port read memory and emits it as a vsync/href/gray pixel stream. Each frame is triggered by a start pulse. Line timing matches the stream consumed by the contrast/curve pixel blocks: a vsync lead before the first line, href for IMG_WIDTH cycles per line, fixed href-low blanking between lines, and a vsync tail after the last line. It sits between an image buffer (BRAM / frame store) and any per-pixel processing chain.

Parameters:
IMG_WIDTH, 500, pixels per line (>=1)
IMG_HEIGHT, 500, lines per frame (>=1)
DATA_W, 8, pixel width in bits
V_LEAD_CYC, 5, cycles vsync is high before the first href of a frame (>=1)
H_BLANK_CYC, 10, href-low cycles between consecutive lines, vsync held high (>=1)
V_TAIL_CYC, 1, vsync-high cycles after the last pixel of the frame (>=1)
ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), memory address width

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
start  in  1  frame request pulse; sampled only when busy==0
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_W  memory read address, row-major (row*IMG_WIDTH+col)
rd_data  in  DATA_W  memory read data, valid exactly 1 cycle after rd_en
img_vsync  out  1  frame-valid, aligned with img_gray
img_href  out  1  line/pixel-valid, aligned with img_gray
img_gray  out  DATA_W  pixel; 0 whenever img_href==0
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst high at a clock edge): all outputs 0 at the next edge; FSM goes to IDLE; pixel, line and address counters clear. Applies mid-frame too; the frame is abandoned with no frame_done.
- FSM states:
  - IDLE: waits for start with busy==0; then goes to V_LEAD.
  - V_LEAD: runs V_LEAD_CYC cycles; then goes to ACTIVE.
  - ACTIVE: runs IMG_WIDTH cycles. On completion it goes to H_BLANK if lines remain, otherwise to V_TAIL.
  - H_BLANK: runs H_BLANK_CYC cycles; then goes to ACTIVE.
  - V_TAIL: runs V_TAIL_CYC cycles; then goes to IDLE.
- Internal stage-0 signals:
  - vs0 = (state != IDLE).
  - hs0 = (state == ACTIVE).
  - rd_en = hs0; rd_addr = running address, incremented on each rd_en.
  - rd_addr is 0 at frame start and ends at IMG_WIDTH*IMG_HEIGHT-1. It is never driven past that value; the counter does not wrap.
- Output stage, one register stage after stage 0 to match the 1-cycle memory latency:
  - img_vsync = vs0 delayed 1 cycle.
  - img_href = hs0 delayed 1 cycle.
  - img_gray = rd_data when img_href, else 0.
- Latency, with start sampled at edge 0:
  - Internal V_LEAD begins at cycle 1; img_vsync rises at cycle 2.
  - First img_href at cycle 2+V_LEAD_CYC.
  - img_vsync stays high for exactly V_LEAD_CYC + IMG_HEIGHT*IMG_WIDTH + (IMG_HEIGHT-1)*H_BLANK_CYC + V_TAIL_CYC cycles.
- busy and frame_done:
  - busy rises at cycle 1 and stays high until img_vsync falls.
  - frame_done pulses in the cycle img_vsync is first low after the frame; busy drops in that same cycle.
- Start rules:
  - start while busy==1 is ignored (not queued).
  - start coincident with frame_done is accepted, since busy==0 in that cycle, giving back-to-back frames.
- Width rules: counters are sized by $clog2 of their maximum value. rd_addr is compared against IMG_WIDTH*IMG_HEIGHT-1 only at frame end.

Decomposition:
- Package img_stream_pkg holds:
  - the state enum typedef (IDLE, V_LEAD, ACTIVE, H_BLANK, V_TAIL);
  - default image dimension constants;
  - a function computing expected vsync-high length, for RTL assertions and bench use.
- One natural sub-module, img_seg_cnt: a loadable down-counter with a terminal-count flag. It is instantiated for the segment timer and for the line counter; the FSM and address counter stay in img_stream_gen.

Test Plan:
- Basic timing. Setup: W=4, H=3, V_LEAD=2, H_BLANK=3, V_TAIL=1; mem[i]=i+0x10; start at cycle 0. Expected:
  - img_vsync high cycles 2..22 (21 cycles);
  - img_href at 4-7, 11-14, 18-21;
  - img_gray 0x10..0x1B in order;
  - frame_done and busy fall at cycle 23.
- Start rejection: same setup, start pulsed at cycles 5 and 22 -> ignored, exactly one frame output. Start at cycle 23 -> second frame, img_vsync rising again at cycle 25.
- Mid-frame reset: rst high at cycle 12 -> all outputs 0 from cycle 13, no frame_done. A later start produces a full frame beginning at rd_addr 0.
- Address bound: W=H=500 defaults, random image -> 250000 href cycles; last rd_addr is 249999; checker compares every pixel against the memory file with 0 mismatches.
- Gray masking: mem all 0xFF -> img_gray==0 in every href-low cycle (lead, blank, tail, idle).
- Degenerate sizes: W=1, H=1, all gaps 1 -> img_vsync high 3 cycles, a single href at cycle 3, frame_done at cycle 5.
